// File: rtl/entity_scan_scheduler.sv
// rtl/entity_scan_scheduler.sv - entity interface bus sequencer: per-frame snapshot scan with interleaved direction writes
//
// Purpose: owns the select/read/write bus of the entity interface. A frame_start
// scans entities 0..NUM_ENT-1 and emits one registered snapshot per entity.
// Direction commands enter a one-entry buffer. Their write cycles are slotted
// between scan reads, so the two never meet on the shared select bus.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   frame_start           single-cycle scan trigger
//   cmd_valid/cmd_ready   command handshake (ready = write buffer empty)
//   cmd_sel, cmd_dir      command target entity and direction code
//   cmd_err               pulse after an illegal cmd_sel is accepted
//   if_select/read/write  interface bus, decoded from registered state only
//   if_dir                direction data for interface writes
//   if_x/y/type           interface data, valid the cycle after if_read
//   if_active             interface active flag, valid in the if_read cycle
//   ent_*                 snapshot stream; ent_valid pulses once per entity
//   scan_busy, scan_done  scan in progress / last snapshot pulse
//   overrun               pulse after a frame_start that hit a running scan
module entity_scan_scheduler #(
  parameter int NUM_ENT = 6,
  parameter int SEL_W   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_start,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic [2:0]       cmd_dir,
  output logic             cmd_err,
  output logic [SEL_W-1:0] if_select,
  output logic             if_read,
  output logic             if_write,
  output logic [2:0]       if_dir,
  input  logic [9:0]       if_x,
  input  logic [9:0]       if_y,
  input  logic [1:0]       if_type,
  input  logic             if_active,
  output logic             ent_valid,
  output logic [SEL_W-1:0] ent_idx,
  output logic [9:0]       ent_x,
  output logic [9:0]       ent_y,
  output logic [1:0]       ent_type,
  output logic             ent_active,
  output logic             scan_busy,
  output logic             scan_done,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_CAP   = 2'd2,
    WR       = 2'd3
  } state_t;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_ENT - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             scanning_q, scanning_d;
  logic             start_pending_q, start_pending_d;
  logic             wbuf_valid_q, wbuf_valid_d;
  logic [SEL_W-1:0] wbuf_sel_q, wbuf_sel_d;
  logic [2:0]       wbuf_dir_q, wbuf_dir_d;
  logic             active_q, active_d;
  logic             ent_valid_q, ent_valid_d;
  logic [SEL_W-1:0] ent_idx_q, ent_idx_d;
  logic [9:0]       ent_x_q, ent_x_d;
  logic [9:0]       ent_y_q, ent_y_d;
  logic [1:0]       ent_type_q, ent_type_d;
  logic             ent_active_q, ent_active_d;
  logic             scan_done_q, scan_done_d;
  logic             cmd_err_q, cmd_err_d;
  logic             overrun_q, overrun_d;

  logic cmd_accept;
  logic cmd_legal;

  // The buffer is full for the whole WR cycle, so an accept can never
  // coincide with the drain that clears it.
  assign cmd_accept = cmd_valid && !wbuf_valid_q;
  // Entity 0 is the player and takes no direction commands.
  assign cmd_legal  = (cmd_sel != '0) && (cmd_sel <= LAST_IDX);

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    scanning_d      = scanning_q;
    start_pending_d = start_pending_q;
    wbuf_valid_d    = wbuf_valid_q;
    wbuf_sel_d      = wbuf_sel_q;
    wbuf_dir_d      = wbuf_dir_q;
    active_d        = active_q;
    ent_valid_d     = 1'b0;
    ent_idx_d       = ent_idx_q;
    ent_x_d         = ent_x_q;
    ent_y_d         = ent_y_q;
    ent_type_d      = ent_type_q;
    ent_active_d    = ent_active_q;
    scan_done_d     = 1'b0;
    cmd_err_d       = cmd_accept && !cmd_legal;
    overrun_d       = frame_start && scanning_q;

    if (frame_start && !scanning_q) begin
      start_pending_d = 1'b1;
    end

    if (cmd_accept && cmd_legal) begin
      wbuf_valid_d = 1'b1;
      wbuf_sel_d   = cmd_sel;
      wbuf_dir_d   = cmd_dir;
    end

    case (state_q)
      IDLE: begin
        if (wbuf_valid_q) begin
          state_d = WR;
        end else if (start_pending_q || frame_start) begin
          state_d         = RD_ISSUE;
          idx_d           = '0;
          scanning_d      = 1'b1;
          start_pending_d = 1'b0;
        end
      end

      WR: begin
        wbuf_valid_d = 1'b0;
        if (scanning_q) begin
          state_d = RD_ISSUE;
        end else if (start_pending_q) begin
          state_d         = RD_ISSUE;
          idx_d           = '0;
          scanning_d      = 1'b1;
          start_pending_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      RD_ISSUE: begin
        // if_active is combinational from the interface, so it is caught
        // here; the registered if_x/y/type arrive one cycle later.
        active_d = if_active;
        state_d  = RD_CAP;
      end

      RD_CAP: begin
        ent_valid_d  = 1'b1;
        ent_idx_d    = idx_q;
        ent_x_d      = if_x;
        ent_y_d      = if_y;
        ent_type_d   = if_type;
        ent_active_d = active_q;
        if (idx_q == LAST_IDX) begin
          scanning_d  = 1'b0;
          scan_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
        // A pending write takes the gap before the next read (at most one
        // per gap, since the buffer holds one entry).
        if (wbuf_valid_q) begin
          state_d = WR;
        end else if (idx_q != LAST_IDX) begin
          state_d = RD_ISSUE;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      scanning_q      <= 1'b0;
      start_pending_q <= 1'b0;
      wbuf_valid_q    <= 1'b0;
      wbuf_sel_q      <= '0;
      wbuf_dir_q      <= 3'd0;
      active_q        <= 1'b0;
      ent_valid_q     <= 1'b0;
      ent_idx_q       <= '0;
      ent_x_q         <= 10'd0;
      ent_y_q         <= 10'd0;
      ent_type_q      <= 2'd0;
      ent_active_q    <= 1'b0;
      scan_done_q     <= 1'b0;
      cmd_err_q       <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      scanning_q      <= scanning_d;
      start_pending_q <= start_pending_d;
      wbuf_valid_q    <= wbuf_valid_d;
      wbuf_sel_q      <= wbuf_sel_d;
      wbuf_dir_q      <= wbuf_dir_d;
      active_q        <= active_d;
      ent_valid_q     <= ent_valid_d;
      ent_idx_q       <= ent_idx_d;
      ent_x_q         <= ent_x_d;
      ent_y_q         <= ent_y_d;
      ent_type_q      <= ent_type_d;
      ent_active_q    <= ent_active_d;
      scan_done_q     <= scan_done_d;
      cmd_err_q       <= cmd_err_d;
      overrun_q       <= overrun_d;
    end
  end

  // Bus decode uses registered state only: no input reaches the bus
  // combinationally.
  always_comb begin
    if_read   = 1'b0;
    if_write  = 1'b0;
    if_select = '0;
    if_dir    = 3'd0;
    case (state_q)
      RD_ISSUE: begin
        if_read   = 1'b1;
        if_select = idx_q;
      end
      WR: begin
        if_write  = 1'b1;
        if_select = wbuf_sel_q;
        if_dir    = wbuf_dir_q;
      end
      default: ;
    endcase
  end

  assign cmd_ready  = !wbuf_valid_q;
  assign cmd_err    = cmd_err_q;
  assign ent_valid  = ent_valid_q;
  assign ent_idx    = ent_idx_q;
  assign ent_x      = ent_x_q;
  assign ent_y      = ent_y_q;
  assign ent_type   = ent_type_q;
  assign ent_active = ent_active_q;
  assign scan_busy  = scanning_q;
  assign scan_done  = scan_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_entity_scan_scheduler.sv
// tb/tb_entity_scan_scheduler.sv - table-driven bench for entity_scan_scheduler
module tb_entity_scan_scheduler;

  localparam int NUM_ENT = 6;
  localparam int SEL_W   = 3;

  logic             clk;
  logic             reset_n;
  logic             frame_start;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [SEL_W-1:0] cmd_sel;
  logic [2:0]       cmd_dir;
  logic             cmd_err;
  logic [SEL_W-1:0] if_select;
  logic             if_read;
  logic             if_write;
  logic [2:0]       if_dir;
  logic [9:0]       if_x;
  logic [9:0]       if_y;
  logic [1:0]       if_type;
  logic             if_active;
  logic             ent_valid;
  logic [SEL_W-1:0] ent_idx;
  logic [9:0]       ent_x;
  logic [9:0]       ent_y;
  logic [1:0]       ent_type;
  logic             ent_active;
  logic             scan_busy;
  logic             scan_done;
  logic             overrun;

  entity_scan_scheduler #(.NUM_ENT(NUM_ENT), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_dir(cmd_dir), .cmd_err(cmd_err),
    .if_select(if_select), .if_read(if_read), .if_write(if_write),
    .if_dir(if_dir), .if_x(if_x), .if_y(if_y), .if_type(if_type),
    .if_active(if_active),
    .ent_valid(ent_valid), .ent_idx(ent_idx), .ent_x(ent_x), .ent_y(ent_y),
    .ent_type(ent_type), .ent_active(ent_active),
    .scan_busy(scan_busy), .scan_done(scan_done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Interface model: X=10*i, Y=20*i, type=i%4 registered on read;
  // active=1 for odd i, combinational; directions stored on write.
  logic [2:0] dmem [0:7];
  always @(posedge clk) begin
    if (if_read) begin
      if_x    <= 10'(10 * int'(if_select));
      if_y    <= 10'(20 * int'(if_select));
      if_type <= if_select[1:0];
    end
    if (if_write) dmem[if_select] <= if_dir;
  end
  assign if_active = if_read ? if_select[0] : 1'b0;

  typedef struct {
    logic       fs;
    logic       cv;
    logic [2:0] cs;
    logic [2:0] cd;
    logic       ev;
    int         eidx;
    logic       rd;
    logic       wr;
    logic [2:0] sel;
    logic [2:0] dir;
    logic       busy;
    logic       done;
    logic       rdy;
    logic       err;
    logic       ovr;
  } vec_t;

  vec_t tbl[$];
  vec_t v;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input int cyc, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic vec_t nv();
    vec_t r;
    r = '{default: 0};
    r.rdy = 1'b1;
    return r;
  endfunction

  function automatic vec_t with_ev(input vec_t a, input int p);
    vec_t r;
    r = a;
    if (p >= 0) begin
      r.ev   = 1'b1;
      r.eidx = p;
      if (p == NUM_ENT - 1) begin
        r.done = 1'b1;
        r.busy = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic run_tbl(input string nm);
    for (int c = 0; c < tbl.size(); c++) begin
      @(negedge clk);
      frame_start = tbl[c].fs;
      cmd_valid   = tbl[c].cv;
      cmd_sel     = tbl[c].cs;
      cmd_dir     = tbl[c].cd;
      chk({nm, "/ent_valid"}, c, int'(ent_valid), int'(tbl[c].ev));
      if (tbl[c].ev) begin
        chk({nm, "/ent_idx"},    c, int'(ent_idx),    tbl[c].eidx);
        chk({nm, "/ent_x"},      c, int'(ent_x),      10 * tbl[c].eidx);
        chk({nm, "/ent_y"},      c, int'(ent_y),      20 * tbl[c].eidx);
        chk({nm, "/ent_type"},   c, int'(ent_type),   tbl[c].eidx % 4);
        chk({nm, "/ent_active"}, c, int'(ent_active), tbl[c].eidx % 2);
      end
      chk({nm, "/if_read"},   c, int'(if_read),   int'(tbl[c].rd));
      chk({nm, "/if_write"},  c, int'(if_write),  int'(tbl[c].wr));
      chk({nm, "/if_select"}, c, int'(if_select), int'(tbl[c].sel));
      chk({nm, "/if_dir"},    c, int'(if_dir),    int'(tbl[c].dir));
      chk({nm, "/scan_busy"}, c, int'(scan_busy), int'(tbl[c].busy));
      chk({nm, "/scan_done"}, c, int'(scan_done), int'(tbl[c].done));
      chk({nm, "/cmd_ready"}, c, int'(cmd_ready), int'(tbl[c].rdy));
      chk({nm, "/cmd_err"},   c, int'(cmd_err),   int'(tbl[c].err));
      chk({nm, "/overrun"},   c, int'(overrun),   int'(tbl[c].ovr));
    end
    frame_start = 1'b0;
    cmd_valid   = 1'b0;
    tbl.delete();
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "/ent_valid"},  0, int'(ent_valid),  0);
    chk({nm, "/ent_idx"},    0, int'(ent_idx),    0);
    chk({nm, "/ent_x"},      0, int'(ent_x),      0);
    chk({nm, "/ent_y"},      0, int'(ent_y),      0);
    chk({nm, "/ent_type"},   0, int'(ent_type),   0);
    chk({nm, "/ent_active"}, 0, int'(ent_active), 0);
    chk({nm, "/if_read"},    0, int'(if_read),    0);
    chk({nm, "/if_write"},   0, int'(if_write),   0);
    chk({nm, "/if_select"},  0, int'(if_select),  0);
    chk({nm, "/if_dir"},     0, int'(if_dir),     0);
    chk({nm, "/scan_busy"},  0, int'(scan_busy),  0);
    chk({nm, "/scan_done"},  0, int'(scan_done),  0);
    chk({nm, "/cmd_ready"},  0, int'(cmd_ready),  1);
    chk({nm, "/cmd_err"},    0, int'(cmd_err),    0);
    chk({nm, "/overrun"},    0, int'(overrun),    0);
  endtask

  // Full scan started at cycle 0; optional command (ws, wd) offered in the
  // RD_ISSUE of entity wr_after, whose write lands right after that capture.
  task automatic gen_scan(input int wr_after, input logic [2:0] ws, input logic [2:0] wd);
    int pev;
    v = nv(); v.fs = 1'b1; tbl.push_back(v);
    pev = -1;
    for (int i = 0; i < NUM_ENT; i++) begin
      v = nv(); v.rd = 1'b1; v.sel = 3'(i); v.busy = 1'b1;
      if (i == wr_after) begin v.cv = 1'b1; v.cs = ws; v.cd = wd; end
      tbl.push_back(with_ev(v, pev));
      v = nv(); v.busy = 1'b1;
      if (i == wr_after) v.rdy = 1'b0;
      tbl.push_back(v);
      pev = i;
      if (i == wr_after) begin
        v = nv(); v.wr = 1'b1; v.sel = ws; v.dir = wd; v.busy = 1'b1; v.rdy = 1'b0;
        tbl.push_back(with_ev(v, pev));
        pev = -1;
      end
    end
    tbl.push_back(with_ev(nv(), pev));
    tbl.push_back(nv());
  endtask

  initial begin
    int pev;
    reset_n     = 1'b0;
    frame_start = 1'b0;
    cmd_valid   = 1'b0;
    cmd_sel     = 3'd0;
    cmd_dir     = 3'd0;

    // Reset held for 3 cycles, then 10 quiet idle cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk_reset_state("reset");
    for (int i = 0; i < 10; i++) tbl.push_back(nv());
    run_tbl("idle");

    // Basic scan: ent_valid at t+3..t+13, scan_done at t+13.
    gen_scan(-1, 3'd0, 3'd0);
    run_tbl("scan");

    // Write to enemy 3 slotted after the capture of entity 1.
    gen_scan(1, 3'd3, 3'd5);
    run_tbl("interleave");
    chk("interleave/dir3", 0, int'(dmem[3]), 5);

    // Illegal selects 0, 7 and 6 are dropped with cmd_err; then the highest
    // legal enemy (5) is written from idle.
    v = nv(); v.cv = 1'b1; v.cs = 3'd0; v.cd = 3'd1; tbl.push_back(v);
    v = nv(); v.err = 1'b1; v.cv = 1'b1; v.cs = 3'd7; v.cd = 3'd2; tbl.push_back(v);
    v = nv(); v.err = 1'b1; v.cv = 1'b1; v.cs = 3'd6; v.cd = 3'd3; tbl.push_back(v);
    v = nv(); v.err = 1'b1; tbl.push_back(v);
    v = nv(); v.cv = 1'b1; v.cs = 3'd5; v.cd = 3'd7; tbl.push_back(v);
    v = nv(); v.rdy = 1'b0; tbl.push_back(v);
    v = nv(); v.rdy = 1'b0; v.wr = 1'b1; v.sel = 3'd5; v.dir = 3'd7; tbl.push_back(v);
    tbl.push_back(nv());
    tbl.push_back(nv());
    run_tbl("cmd");
    chk("cmd/dir5", 0, int'(dmem[5]), 7);

    // Write pending when frame_start arrives: WR first, then scan from 0;
    // a frame_start during the scan only raises overrun.
    v = nv(); v.cv = 1'b1; v.cs = 3'd2; v.cd = 3'd6; tbl.push_back(v);
    v = nv(); v.fs = 1'b1; v.rdy = 1'b0; tbl.push_back(v);
    v = nv(); v.wr = 1'b1; v.sel = 3'd2; v.dir = 3'd6; v.rdy = 1'b0; tbl.push_back(v);
    pev = -1;
    for (int i = 0; i < NUM_ENT; i++) begin
      v = nv(); v.rd = 1'b1; v.sel = 3'(i); v.busy = 1'b1;
      if (i == 1) v.ovr = 1'b1;
      tbl.push_back(with_ev(v, pev));
      v = nv(); v.busy = 1'b1;
      if (i == 0) v.fs = 1'b1;
      tbl.push_back(v);
      pev = i;
    end
    tbl.push_back(with_ev(nv(), pev));
    tbl.push_back(nv());
    tbl.push_back(nv());
    tbl.push_back(nv());
    run_tbl("priority");
    chk("priority/dir2", 0, int'(dmem[2]), 6);

    // Reset during the RD_CAP of entity 2 (cycle 6 after frame_start).
    v = nv(); v.fs = 1'b1; tbl.push_back(v);
    pev = -1;
    for (int i = 0; i < 3; i++) begin
      v = nv(); v.rd = 1'b1; v.sel = 3'(i); v.busy = 1'b1;
      tbl.push_back(with_ev(v, pev));
      if (i < 2) begin
        v = nv(); v.busy = 1'b1; tbl.push_back(v);
      end
      pev = i;
    end
    run_tbl("midreset_pre");
    @(negedge clk);
    chk("midreset/rdcap_read", 6, int'(if_read), 0);
    chk("midreset/rdcap_busy", 6, int'(scan_busy), 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk_reset_state("midreset");
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) tbl.push_back(nv());
    run_tbl("midreset_quiet");
    gen_scan(-1, 3'd0, 3'd0);
    run_tbl("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
